// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide owning HI/LO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic div_r, neg_q, neg_r, skip;
  logic [WIDTH-1:0] d;
  logic [2*WIDTH-1:0] acc;
  logic accept, signed_op, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0] add_sum, trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  // Operand magnitudes and one shift-add / restoring-subtract step
  always_comb begin
    accept    = start && !busy;
    signed_op = (op == 3'd0) || (op == 3'd2);
    is_div    = (op == 3'd2) || (op == 3'd3);
    a_neg     = signed_op && a[WIDTH-1];
    b_neg     = signed_op && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
    mul_next  = {add_sum, acc[WIDTH-1:1]};
    trial     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, d};
    div_next  = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix  = neg_q ? -acc : acc;
    q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  // Control FSM, datapath iteration and HI/LO writeback
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      div_r       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      skip        <= 1'b0;
      d           <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (op == 3'd4) hi <= a;
          else if (op == 3'd5) lo <= a;
          else if (!op[2]) begin
            div_r <= is_div;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            skip  <= is_div && (b == '0);
            d     <= is_div ? b_mag : a_mag;
            acc   <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (is_div && (b == '0)) ? FIX : CALC;
          end
        end
        CALC: begin
          acc   <= div_r ? div_next : mul_next;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(WIDTH-1)) ? FIX : CALC;
        end
        FIX: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= skip;
          if (!skip) begin
            hi <= div_r ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo <= div_r ? q_fix : prod_fix[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  int passed = 0, total = 0, n = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(posedge clock);
      #1 cycles++;
    end while (!done && cycles < 100);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clock) reset = 1'b0;

    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy", busy, 1);
    wait_done(n);
    chk("mult_lat", n, 33);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    chk("mult_idle", busy, 0);

    issue(MULTU, 32'hFFFF_FFFD, 32'd5);
    wait_done(n);
    chk("multu_hi", hi, 32'h0000_0004);
    chk("multu_lo", lo, 32'hFFFF_FFF1);

    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    chk("div_lat", n, 33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(DIVU, 32'hFFFF_FFFF, 32'h10);
    wait_done(n);
    chk("divu_lo", lo, 32'h0FFF_FFFF);
    chk("divu_hi", hi, 32'h0000_000F);

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 0);
    chk("ovf_dbz", div_by_zero, 0);

    issue(MTHI, 32'h11, 32'h0);
    issue(MTLO, 32'h22, 32'h0);
    issue(DIV, 32'h55, 32'h0);
    chk("dbz_busy", busy, 1);
    wait_done(n);
    chk("dbz_lat", n, 1);
    chk("dbz_flag", div_by_zero, 1);
    chk("dbz_hi", hi, 32'h11);
    chk("dbz_lo", lo, 32'h22);
    chk("dbz_nbusy", busy, 0);
    @(posedge clock) #1;
    chk("dbz_pulse", {done, div_by_zero}, 0);

    issue(MTHI, 32'hDEAD_BEEF, 32'h0);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_bd", {busy, done}, 0);
    issue(MTLO, 32'h1234_5678, 32'h0);
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_hi", hi, 32'hDEAD_BEEF);
    chk("mtlo_bd", {busy, done}, 0);

    issue(MULT, 32'd100, 32'd3);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      op = DIVU; a = 32'd1000; b = 32'd7;
      start = (i == 5) || (i == 20) || (i >= 30);
      @(posedge clock);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    chk("drop_lat", n, 33);
    chk("drop_lo", lo, 32'd300);
    chk("drop_hi", hi, 0);
    @(posedge clock);
    #1 start = 1'b0;
    chk("held_busy", busy, 1);
    wait_done(n);
    chk("held_lat", n, 33);
    chk("held_lo", lo, 32'd142);
    chk("held_hi", hi, 32'd6);

    issue(DIV, 32'd100, 32'd3);
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clock) reset = 1'b0;
    issue(MULT, 32'd6, 32'd7);
    wait_done(n);
    chk("post_lat", n, 33);
    chk("post_lo", lo, 32'd42);
    chk("post_hi", hi, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
